himax_capture_ctrl: RTL and testbench
=====================================

// Module: himax_capture_ctrl
// PURPOSE
// Sequences the Himax camera path. After power-on it waits a settling delay, triggers the I2C
// init ROM and gates sensor_clk. It then arms single-frame or continuous capture on host
// command. It also turns the clk-domain pixel stream (output of the cc561 crossing) into
// frame-buffer writes, with bounds, timeout and size checking.
// PARAMETERS
// INIT_WAIT_W  21     power-on wait counter width; wait = 2**INIT_WAIT_W clk cycles
// FRAME_PIX    79056  bytes per frame (324x244, 8 bpp)
// ADDR_W       17     frame-buffer address width; FRAME_PIX <= 2**ADDR_W
// TIMEOUT_W    24     watchdog width; timeout = 2**TIMEOUT_W-1 cycles (~0.7 s at 24 MHz)
// DRAIN_CYC    8      clk cycles pixels are still accepted after synced FV fall
// PORTS
// clk          in   1       system clock (HSOSC, 24 MHz)
// rst          in   1       asynchronous, active-high reset
// cmd_start    in   1       1-cycle pulse: capture one frame (or start continuous)
// cmd_cont     in   1       level: 1 = re-arm automatically after each frame
// cmd_abort    in   1       1-cycle pulse: stop any capture, return to IDLE
// init         out  1       1-cycle pulse to the I2C init master
// init_done    in   1       level from the I2C init master
// sensor_clk_en out 1       1 until init_done seen, then 0 (gates sensor_clk)
// px_fv        in   1       raw frame-valid, px_clk domain (synchronised here)
// pixel_data   in   8       pixel byte, clk domain
// pixel_vld    in   1       1-cycle qualifier for pixel_data
// wr_en        out  1       frame-buffer write strobe
// wr_addr      out  ADDR_W  frame-buffer byte address
// wr_data      out  8       frame-buffer write data
// ready        out  1       1 in IDLE only
// busy         out  1       1 in ARM/SOF/CAPTURE/DRAIN
// frame_done   out  1       1-cycle pulse at end of a captured frame
// frame_cnt    out  16      completed frames, wraps 0xFFFF->0
// last_len     out  ADDR_W+1 pixel count of the last completed frame
// err_timeout  out  1       sticky; cleared by next cmd_start
// err_size     out  1       sticky: last_len != FRAME_PIX; cleared by next cmd_start
// err_ovf      out  1       sticky: pixel dropped at address FRAME_PIX; cleared by cmd_start
// BEHAVIOUR
// - Reset: state=POR_WAIT; all outputs 0 except sensor_clk_en=1; counters cleared.
// - px_fv: 2-flop synchroniser, then rise/fall detect (fv_rise/fv_fall 1-cycle, 3-cycle latency).
// - FSM:
//   POR_WAIT: timer counts up; at all-ones -> PROG.
//   PROG: init=1 for exactly 1 cycle -> INIT_WAIT.
//   INIT_WAIT: on init_done -> IDLE; sensor_clk_en drops the same edge.
//   IDLE: on cmd_start -> ARM; clears err_*.
//   ARM: waits for synced fv==0, so no partial frame is captured -> SOF.
//   SOF: on fv_rise -> CAPTURE; wr_addr=0.
//   CAPTURE: on fv_fall -> DRAIN.
//   DRAIN: DRAIN_CYC cycles -> DONE.
//   DONE (1 cycle): frame_done=1, frame_cnt++, last_len latched, err_size updated;
//     -> SOF if cmd_cont=1, else IDLE.
// - Priority in a cycle: cmd_abort > timeout > fv events > pixel writes.
// - Ignored commands: cmd_start outside IDLE; cmd_abort outside ARM/SOF/CAPTURE/DRAIN/DONE.
// - Abort: from ARM/SOF/CAPTURE/DRAIN/DONE go to IDLE next cycle. No frame_done; frame_cnt and
//   last_len unchanged. If abort coincides with DONE, the DONE outputs still fire.
// - Writes: in CAPTURE and DRAIN, pixel_vld at cycle n gives wr_en=1 at n+1, with
//   wr_data=pixel_data and wr_addr=pix_cnt. pix_cnt is ADDR_W+1 bits and increments per accepted pixel.
// - Overflow: pixel_vld with pix_cnt==FRAME_PIX sets err_ovf; no write; pix_cnt saturates.
// - pixel_vld outside CAPTURE/DRAIN is discarded silently.
// - Watchdog: cleared on every state change and every accepted pixel; counts in ARM/SOF/CAPTURE.
//   At all-ones: err_timeout=1 -> IDLE; cmd_cont is not honoured.
// - A DONE->SOF transition in continuous mode does not clear err_* (errors accumulate).
// - Counts: frame_cnt wraps modulo 2**16.
// STRUCTURE
// - himax_pkg: state enum cap_state_t, FRAME_PIX/ADDR_W defaults, HM01B0 width/height constants.
// - Sub-module sync_edge_det: 2-FF synchroniser plus rise/fall pulses, reused for px_fv.
// - Remainder in one file: FSM, POR timer, watchdog, write pipeline register.
// TESTING (DV bench: INIT_WAIT_W=4, FRAME_PIX=16, TIMEOUT_W=8, DRAIN_CYC=4)
// - Boot: release rst; init pulses once at cycle 17. Hold init_done at 1 -> ready=1,
//   sensor_clk_en=0 one cycle later.
// - Single frame: cmd_start, FV pulse carrying 16 pixels 0x00..0x0F -> 16 writes at addresses
//   0..15 matching data, then frame_done once, frame_cnt=1, last_len=16, no errors, ready=1.
// - Mid-frame arm: cmd_start while fv=1 -> no writes until that frame ends; the next full frame
//   is captured at addresses 0..15.
// - Size/overflow: frame of 18 pixels -> 16 writes, err_ovf=1, err_size=1, last_len=16.
//   Frame of 10 pixels -> err_size=1, last_len=10.
// - Continuous and abort: cmd_cont=1 over 3 frames -> frame_cnt=3, no return to IDLE. cmd_abort
//   during the 4th CAPTURE -> IDLE next cycle, no frame_done, frame_cnt=3.
// - Timeout: cmd_start with fv held at 0 -> err_timeout=1 after 255 cycles in SOF, ready=1.
//   The next cmd_start clears err_timeout.

Source files
------------

// File: rtl/himax_pkg.sv
// himax_pkg: capture FSM states and HM01B0 frame geometry shared by the capture path.
package himax_pkg;
  typedef enum logic [3:0] {
    POR_WAIT, PROG, INIT_WAIT, IDLE, ARM, SOF, CAPTURE, DRAIN, DONE
  } cap_state_t;
  localparam int HM01B0_W = 324;
  localparam int HM01B0_H = 244;
  localparam int FRAME_PIX_DEF = HM01B0_W * HM01B0_H;
  localparam int ADDR_W_DEF = 17;
endpackage

// File: rtl/himax_capture_ctrl_sync.sv
// sync_edge_det: 2-FF synchroniser with registered rise/fall pulses (3-cycle latency).
module sync_edge_det (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic lvl_o,
  output logic rise_o,
  output logic fall_o
);
  logic [2:0] s_q;
  logic rise_q, fall_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_q <= '0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      s_q <= {s_q[1:0], d_i};
      rise_q <= s_q[1] & ~s_q[2];
      fall_q <= ~s_q[1] & s_q[2];
    end
  end
  assign lvl_o = s_q[1];
  assign rise_o = rise_q;
  assign fall_o = fall_q;
endmodule

// File: rtl/himax_capture_ctrl.sv
// himax_capture_ctrl: power-on/init sequencing and single/continuous frame capture into a frame buffer.
module himax_capture_ctrl
  import himax_pkg::*;
#(
  parameter int INIT_WAIT_W = 21,
  parameter int FRAME_PIX = FRAME_PIX_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int TIMEOUT_W = 24,
  parameter int DRAIN_CYC = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_start,
  input  logic              cmd_cont,
  input  logic              cmd_abort,
  output logic              init,
  input  logic              init_done,
  output logic              sensor_clk_en,
  input  logic              px_fv,
  input  logic [7:0]        pixel_data,
  input  logic              pixel_vld,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0]        wr_data,
  output logic              ready,
  output logic              busy,
  output logic              frame_done,
  output logic [15:0]       frame_cnt,
  output logic [ADDR_W:0]   last_len,
  output logic              err_timeout,
  output logic              err_size,
  output logic              err_ovf
);
  localparam int PIX_W = ADDR_W + 1;
  localparam int DW = $clog2(DRAIN_CYC) + 1;
  cap_state_t state_q, state_d;
  logic [INIT_WAIT_W-1:0] por_q, por_d;
  logic [TIMEOUT_W-1:0] wd_q, wd_d;
  logic [DW-1:0] drn_q, drn_d;
  logic [PIX_W-1:0] pix_q, pix_d, len_q, len_d;
  logic [15:0] cnt_q, cnt_d;
  logic et_q, et_d, es_q, es_d, eo_q, eo_d, sce_q, sce_d, wen_q, wen_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [7:0] wdata_q, wdata_d;
  logic fv, fv_rise, fv_fall, wd_run, tmo, abort, in_cap;
  sync_edge_det u_fv_sync (
    .clk(clk), .rst(rst), .d_i(px_fv), .lvl_o(fv), .rise_o(fv_rise), .fall_o(fv_fall)
  );
  assign wd_run = state_q inside {ARM, SOF, CAPTURE};
  assign tmo = wd_run & (&wd_q);
  assign abort = cmd_abort & (state_q inside {ARM, SOF, CAPTURE, DRAIN, DONE});
  assign in_cap = state_q inside {CAPTURE, DRAIN};
  always_comb begin
    state_d = state_q;
    por_d = por_q;
    drn_d = drn_q;
    pix_d = pix_q;
    len_d = len_q;
    cnt_d = cnt_q;
    et_d = et_q;
    es_d = es_q;
    eo_d = eo_q;
    sce_d = sce_q;
    wen_d = 1'b0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    case (state_q)
      POR_WAIT:  if (&por_q) state_d = PROG; else por_d = por_q + 1'b1;
      PROG:      state_d = INIT_WAIT;
      INIT_WAIT: if (init_done) begin state_d = IDLE; sce_d = 1'b0; end
      IDLE:      if (cmd_start) begin state_d = ARM; et_d = 1'b0; es_d = 1'b0; eo_d = 1'b0; end
      ARM:       if (!fv) state_d = SOF;
      SOF:       if (fv_rise) begin state_d = CAPTURE; pix_d = '0; end
      CAPTURE:   if (fv_fall) state_d = DRAIN;
      DRAIN:     if (drn_q == DW'(DRAIN_CYC - 1)) state_d = DONE; else drn_d = drn_q + 1'b1;
      DONE:      state_d = cmd_cont ? SOF : IDLE;
      default:   state_d = IDLE;
    endcase
    if (in_cap && pixel_vld && !abort && !tmo) begin
      if (pix_q == PIX_W'(FRAME_PIX)) eo_d = 1'b1;
      else begin
        wen_d = 1'b1;
        waddr_d = pix_q[ADDR_W-1:0];
        wdata_d = pixel_data;
        pix_d = pix_q + 1'b1;
      end
    end
    if (tmo) begin state_d = IDLE; et_d = 1'b1; end
    if (abort) state_d = IDLE;
    // frame bookkeeping is committed on entry to DONE so it lines up with frame_done
    if (state_q == DRAIN && state_d == DONE) begin
      cnt_d = cnt_q + 16'd1;
      len_d = pix_d;
      es_d = es_q | (pix_d != PIX_W'(FRAME_PIX)) | eo_d;
    end
    if (state_d != state_q) drn_d = '0;
    wd_d = (state_d != state_q || wen_d) ? '0 : (wd_run ? wd_q + 1'b1 : wd_q);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= POR_WAIT;
      por_q <= '0;
      wd_q <= '0;
      drn_q <= '0;
      pix_q <= '0;
      len_q <= '0;
      cnt_q <= '0;
      et_q <= 1'b0;
      es_q <= 1'b0;
      eo_q <= 1'b0;
      sce_q <= 1'b1;
      wen_q <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      por_q <= por_d;
      wd_q <= wd_d;
      drn_q <= drn_d;
      pix_q <= pix_d;
      len_q <= len_d;
      cnt_q <= cnt_d;
      et_q <= et_d;
      es_q <= es_d;
      eo_q <= eo_d;
      sce_q <= sce_d;
      wen_q <= wen_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
    end
  end
  assign init = state_q == PROG;
  assign sensor_clk_en = sce_q;
  assign ready = state_q == IDLE;
  assign busy = state_q inside {ARM, SOF, CAPTURE, DRAIN};
  assign frame_done = state_q == DONE;
  assign frame_cnt = cnt_q;
  assign last_len = len_q;
  assign err_timeout = et_q;
  assign err_size = es_q;
  assign err_ovf = eo_q;
  assign wr_en = wen_q;
  assign wr_addr = waddr_q;
  assign wr_data = wdata_q;
endmodule

// File: tb/tb_himax_capture_ctrl.sv
// tb_himax_capture_ctrl: directed boot, capture, size, continuous/abort and timeout scenarios.
module tb_himax_capture_ctrl;
  logic clk = 1'b0, rst = 1'b1;
  logic cmd_start = 0, cmd_cont = 0, cmd_abort = 0, init_done = 1, px_fv = 0, pixel_vld = 0;
  logic [7:0] pixel_data = 0;
  logic init, sensor_clk_en, wr_en, ready, busy, frame_done, err_timeout, err_size, err_ovf;
  logic [3:0] wr_addr;
  logic [7:0] wr_data;
  logic [15:0] frame_cnt;
  logic [4:0] last_len;
  int errors = 0, checks = 0;
  int wn = 0, dn = 0;
  logic [3:0] wa [256];
  logic [7:0] wdat [256];

  himax_capture_ctrl #(.INIT_WAIT_W(4), .FRAME_PIX(16), .ADDR_W(4), .TIMEOUT_W(8), .DRAIN_CYC(4)) dut (
    .clk(clk), .rst(rst), .cmd_start(cmd_start), .cmd_cont(cmd_cont), .cmd_abort(cmd_abort),
    .init(init), .init_done(init_done), .sensor_clk_en(sensor_clk_en), .px_fv(px_fv),
    .pixel_data(pixel_data), .pixel_vld(pixel_vld), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .ready(ready), .busy(busy), .frame_done(frame_done), .frame_cnt(frame_cnt),
    .last_len(last_len), .err_timeout(err_timeout), .err_size(err_size), .err_ovf(err_ovf)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (wr_en && wn < 256) begin wa[wn] = wr_addr; wdat[wn] = wr_data; wn = wn + 1; end
    if (frame_done) dn = dn + 1;
  end

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic pulse_start();
    cmd_start = 1; tick(1); cmd_start = 0;
  endtask

  task automatic send_pix(input int n, input logic [7:0] base);
    for (int i = 0; i < n; i++) begin
      pixel_vld = 1; pixel_data = base + 8'(i); tick(1);
    end
    pixel_vld = 0;
  endtask

  task automatic run_frame(input int n, input logic [7:0] base);
    int d0, k;
    d0 = dn;
    px_fv = 1; tick(6);
    send_pix(n, base);
    tick(4); px_fv = 0;
    k = 0;
    while (dn == d0 && k < 40) begin tick(1); k++; end
    checks++;
    if (dn == d0) begin errors++; $display("FAIL frame_done_wait: got none within %0d cycles, required one", k); end
    tick(2);
  endtask

  task automatic test_reset();
    tick(1);
    checks++;
    if ({init, sensor_clk_en, ready, busy, frame_done, wr_en, err_timeout, err_size, err_ovf} !== 9'b010000000 || frame_cnt !== 0 || last_len !== 0) begin
      errors++; $display("FAIL reset_outputs: init=%b sce=%b ready=%b busy=%b cnt=%0d, required sce=1 rest 0", init, sensor_clk_en, ready, busy, frame_cnt);
    end
  endtask

  task automatic test_boot();
    int n = 0;
    @(posedge clk); #1 rst = 0;
    while (!init && n < 40) begin tick(1); n++; end
    checks++;
    if (n !== 16) begin errors++; $display("FAIL init_time: got init after %0d cycles, required 16", n); end
    tick(1);
    checks++;
    if (init !== 0 || ready !== 0 || sensor_clk_en !== 1) begin
      errors++; $display("FAIL init_pulse: init=%b ready=%b sce=%b, required 0 0 1", init, ready, sensor_clk_en);
    end
    tick(1);
    checks++;
    if (ready !== 1 || sensor_clk_en !== 0) begin
      errors++; $display("FAIL boot_ready: ready=%b sce=%b, required 1 0", ready, sensor_clk_en);
    end
  endtask

  task automatic test_single_frame();
    int w0 = wn, d0 = dn;
    pulse_start();
    run_frame(16, 8'h00);
    checks++;
    if (wn - w0 !== 16) begin errors++; $display("FAIL single_wr_count: got %0d, required 16", wn - w0); end
    for (int i = 0; i < 16 && w0 + i < wn; i++) begin
      checks++;
      if (wa[w0+i] !== 4'(i) || wdat[w0+i] !== 8'(i)) begin
        errors++; $display("FAIL single_wr[%0d]: addr=%0d data=%0h, required addr=%0d data=%0h", i, wa[w0+i], wdat[w0+i], i, i);
      end
    end
    checks++;
    if (dn - d0 !== 1 || frame_cnt !== 16'd1 || last_len !== 5'd16) begin
      errors++; $display("FAIL single_done: pulses=%0d cnt=%0d len=%0d, required 1 1 16", dn - d0, frame_cnt, last_len);
    end
    checks++;
    if ({err_timeout, err_size, err_ovf} !== 3'b000 || ready !== 1) begin
      errors++; $display("FAIL single_status: errs=%b ready=%b, required 000 1", {err_timeout, err_size, err_ovf}, ready);
    end
  endtask

  task automatic test_mid_frame_arm();
    int w0 = wn;
    px_fv = 1; tick(5);
    pulse_start();
    send_pix(8, 8'hA0);
    tick(2); px_fv = 0; tick(6);
    checks++;
    if (wn - w0 !== 0 || busy !== 1) begin
      errors++; $display("FAIL mid_no_write: writes=%0d busy=%b, required 0 1", wn - w0, busy);
    end
    run_frame(16, 8'h40);
    checks++;
    if (wn - w0 !== 16) begin errors++; $display("FAIL mid_wr_count: got %0d, required 16", wn - w0); end
    for (int i = 0; i < 16 && w0 + i < wn; i++) begin
      checks++;
      if (wa[w0+i] !== 4'(i) || wdat[w0+i] !== 8'h40 + 8'(i)) begin
        errors++; $display("FAIL mid_wr[%0d]: addr=%0d data=%0h, required addr=%0d data=%0h", i, wa[w0+i], wdat[w0+i], i, 8'h40 + 8'(i));
      end
    end
    checks++;
    if (frame_cnt !== 16'd2 || ready !== 1) begin
      errors++; $display("FAIL mid_done: cnt=%0d ready=%b, required 2 1", frame_cnt, ready);
    end
  endtask

  task automatic test_size_ovf();
    int w0 = wn;
    pulse_start();
    run_frame(18, 8'h80);
    checks++;
    if (wn - w0 !== 16 || err_ovf !== 1 || err_size !== 1 || last_len !== 5'd16 || frame_cnt !== 16'd3) begin
      errors++; $display("FAIL ovf_frame: writes=%0d ovf=%b size=%b len=%0d cnt=%0d, required 16 1 1 16 3", wn - w0, err_ovf, err_size, last_len, frame_cnt);
    end
    checks++;
    if (wn > w0 && (wa[wn-1] !== 4'd15 || wdat[wn-1] !== 8'h8F)) begin
      errors++; $display("FAIL ovf_last_wr: addr=%0d data=%0h, required 15 8f", wa[wn-1], wdat[wn-1]);
    end
    w0 = wn;
    pulse_start();
    run_frame(10, 8'h20);
    checks++;
    if (wn - w0 !== 10 || err_ovf !== 0 || err_size !== 1 || last_len !== 5'd10 || frame_cnt !== 16'd4) begin
      errors++; $display("FAIL short_frame: writes=%0d ovf=%b size=%b len=%0d cnt=%0d, required 10 0 1 10 4", wn - w0, err_ovf, err_size, last_len, frame_cnt);
    end
  endtask

  task automatic test_cont_abort();
    int d0;
    cmd_cont = 1;
    pulse_start();
    for (int f = 0; f < 3; f++) begin
      run_frame(16, 8'(16 * f));
      checks++;
      if (frame_cnt !== 16'(5 + f) || ready !== 0 || busy !== 1 || err_size !== 0) begin
        errors++; $display("FAIL cont_frame%0d: cnt=%0d ready=%b busy=%b size=%b, required %0d 0 1 0", f, frame_cnt, ready, busy, err_size, 5 + f);
      end
    end
    d0 = dn;
    px_fv = 1; tick(6);
    send_pix(5, 8'h55);
    cmd_abort = 1; tick(1); cmd_abort = 0;
    checks++;
    if (ready !== 1 || busy !== 0) begin
      errors++; $display("FAIL abort_idle: ready=%b busy=%b, required 1 0", ready, busy);
    end
    px_fv = 0; cmd_cont = 0; tick(15);
    checks++;
    if (dn !== d0 || frame_cnt !== 16'd7 || last_len !== 5'd16 || ready !== 1) begin
      errors++; $display("FAIL abort_counts: pulses=%0d cnt=%0d len=%0d ready=%b, required 0 7 16 1", dn - d0, frame_cnt, last_len, ready);
    end
  endtask

  task automatic test_timeout();
    int n = 0;
    pulse_start();
    while (!ready && n < 400) begin tick(1); n++; end
    checks++;
    if (n !== 257 || err_timeout !== 1) begin
      errors++; $display("FAIL timeout: ready after %0d cycles err_timeout=%b, required 257 1", n, err_timeout);
    end
    pulse_start();
    checks++;
    if (err_timeout !== 0 || busy !== 1) begin
      errors++; $display("FAIL timeout_clear: err_timeout=%b busy=%b, required 0 1", err_timeout, busy);
    end
    cmd_abort = 1; tick(1); cmd_abort = 0;
    checks++;
    if (ready !== 1 || frame_cnt !== 16'd7) begin
      errors++; $display("FAIL final_idle: ready=%b cnt=%0d, required 1 7", ready, frame_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_boot();
    test_single_frame();
    test_mid_frame_arm();
    test_size_ovf();
    test_cont_abort();
    test_timeout();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
